// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting agents
// and the round-robin decoded-select arbiter.
interface rr_decode_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter driving a 3-to-8 decoded
// select; grants held until done, owner drop or timeout.
module rr_decode_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst,
  rr_decode_arbiter_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST =
    TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_e     state_q;
  logic [2:0] last_q;
  logic [7:0] cnt_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;
  logic       to_q;

  logic       win_vld_d;
  logic [2:0] win_d;
  logic       rel_d;
  logic       to_hit_d;

  function automatic logic [7:0] dec3to8(
    input logic [2:0] s
  );
    logic [7:0] y;
    case (s)
      3'd0:    y = 8'h01;
      3'd1:    y = 8'h02;
      3'd2:    y = 8'h04;
      3'd3:    y = 8'h08;
      3'd4:    y = 8'h10;
      3'd5:    y = 8'h20;
      3'd6:    y = 8'h40;
      default: y = 8'h80;
    endcase
    return y;
  endfunction

  // Search upward from the slot after the last owner,
  // wrapping naturally through the 3-bit sum.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!win_vld_d && bus.req[last_q + 3'(k)]) begin
        win_vld_d = 1'b1;
        win_d     = last_q + 3'(k);
      end
    end
  end

  always_comb begin
    rel_d    = bus.done || !bus.req[idx_q];
    to_hit_d = TO_EN && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 3'd7;
      cnt_q   <= 8'd0;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q <= S_GRANT;
            gnt_q   <= dec3to8(win_d);
            idx_q   <= win_d;
            valid_q <= 1'b1;
            last_q  <= win_d;
            cnt_q   <= 8'd0;
          end
        end
        S_GRANT: begin
          // done and drop outrank timeout
          if (rel_d || to_hit_d) begin
            state_q <= S_IDLE;
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
            to_q    <= !rel_d;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 8'h00;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: three instances (TIMEOUT
// 16, 0, 4) share stimulus and are checked against a model.
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int TOV [3] = '{16, 0, 4};

  rr_decode_arbiter_if b16 ();
  rr_decode_arbiter_if b0 ();
  rr_decode_arbiter_if b4 ();

  assign b16.req  = req;
  assign b16.done = done;
  assign b0.req   = req;
  assign b0.done  = done;
  assign b4.req   = req;
  assign b4.done  = done;

  rr_decode_arbiter #(.TIMEOUT(16)) u16 (
    .clk(clk), .rst(rst), .bus(b16.slave));
  rr_decode_arbiter #(.TIMEOUT(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  rr_decode_arbiter #(.TIMEOUT(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave));

  logic [7:0] o_gnt [3];
  logic [2:0] o_idx [3];
  logic       o_vld [3];
  logic       o_to  [3];

  assign o_gnt[0] = b16.gnt;
  assign o_idx[0] = b16.gnt_idx;
  assign o_vld[0] = b16.gnt_valid;
  assign o_to[0]  = b16.timeout;
  assign o_gnt[1] = b0.gnt;
  assign o_idx[1] = b0.gnt_idx;
  assign o_vld[1] = b0.gnt_valid;
  assign o_to[1]  = b0.timeout;
  assign o_gnt[2] = b4.gnt;
  assign o_idx[2] = b4.gnt_idx;
  assign o_vld[2] = b4.gnt_valid;
  assign o_to[2]  = b4.timeout;

  always #5 clk = ~clk;

  // reference model, one per instance
  bit       m_act  [3];
  bit [2:0] m_idx  [3];
  bit [2:0] m_last [3];
  int       m_cnt  [3];
  bit       m_to   [3];

  function automatic logic [7:0] m_gnt(int i);
    return m_act[i] ? (8'd1 << m_idx[i]) : 8'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i]  = 0;
        m_idx[i]  = 0;
        m_last[i] = 7;
        m_cnt[i]  = 0;
        m_to[i]   = 0;
      end else begin
        m_to[i] = 0;
        if (!m_act[i]) begin
          for (int k = 1; k <= 8; k++) begin
            int j;
            j = (int'(m_last[i]) + k) % 8;
            if (!m_act[i] && req[j]) begin
              m_act[i]  = 1;
              m_idx[i]  = 3'(j);
              m_last[i] = 3'(j);
              m_cnt[i]  = 0;
            end
          end
        end else if (done || !req[m_idx[i]]) begin
          m_act[i] = 0;
        end else if (TOV[i] != 0 &&
                     m_cnt[i] == TOV[i] - 1) begin
          m_act[i] = 0;
          m_to[i]  = 1;
        end else begin
          m_cnt[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({o_gnt[i], o_idx[i], o_vld[i], o_to[i]}
          !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_vals inst%0d: got %h want 0",
          i, {o_gnt[i], o_idx[i], o_vld[i], o_to[i]});
      end
    end
    rst = 1'b0;
    step();
    n_tests++;
    if ({b16.gnt, b16.gnt_idx, b16.gnt_valid}
        !== {8'h01, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL first_grant: got gnt=%h idx=%0d v=%b want 01/0/1",
        b16.gnt, b16.gnt_idx, b16.gnt_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if ({b16.gnt, b16.gnt_idx} !== {8'h20, 3'd5}) begin
        n_fail++;
        $display("FAIL single_hold c%0d: got %h/%0d want 20/5",
          c, b16.gnt, b16.gnt_idx);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++;
    if ({b16.gnt, b16.gnt_idx, b16.gnt_valid}
        !== {8'h00, 3'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL single_release: got %h/%0d/%b want 00/5/0",
        b16.gnt, b16.gnt_idx, b16.gnt_valid);
    end
    n_tests++;
    if ({b4.gnt, b4.timeout} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL done_vs_to4: got %h/%b want 00/0",
        b4.gnt, b4.timeout);
    end
    step();
    n_tests++;
    if ({b16.gnt, b16.gnt_idx} !== {8'h20, 3'd5}) begin
      n_fail++;
      $display("FAIL single_regrant: got %h/%0d want 20/5",
        b16.gnt, b16.gnt_idx);
    end
  endtask

  task automatic test_rotation(input logic [7:0] r,
                               input int n);
    int e;
    do_reset();
    req = r;
    for (int k = 0; k < n; k++) begin
      e = (r == 8'h81) ? ((k % 2) ? 7 : 0) : (k % 8);
      step();
      n_tests++;
      if ({b0.gnt, b0.gnt_idx, b0.gnt_valid}
          !== {8'(1 << e), 3'(e), 1'b1}) begin
        n_fail++;
        $display("FAIL rot_%h k%0d: got %h/%0d want %h/%0d",
          r, k, b0.gnt, b0.gnt_idx, 8'(1 << e), e);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_tests++;
      if ({b0.gnt, b0.gnt_valid} !== 9'h0) begin
        n_fail++;
        $display("FAIL rot_gap k%0d: got %h want 00", k, b0.gnt);
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    do_reset();
    req  = 8'h04;
    done = 1'b0;
    step();
    len = 0;
    while (b16.gnt == 8'h04 && len < 40) begin
      len++;
      step();
    end
    n_tests++;
    if (len !== 16) begin
      n_fail++;
      $display("FAIL to_len: got %0d want 16", len);
    end
    n_tests++;
    if ({b16.gnt, b16.gnt_valid, b16.timeout}
        !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL to_pulse: got %h/%b/%b want 00/0/1",
        b16.gnt, b16.gnt_valid, b16.timeout);
    end
    step();
    n_tests++;
    if ({b16.gnt, b16.timeout} !== {8'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL to_after: got %h/%b want 04/0",
        b16.gnt, b16.timeout);
    end
    repeat (15) step();
    n_tests++;
    if (b16.gnt !== 8'h04) begin
      n_fail++;
      $display("FAIL to_cnt15: got %h want 04", b16.gnt);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_tests++;
    if ({b16.gnt, b16.timeout} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL done_vs_to: got %h/%b want 00/0",
        b16.gnt, b16.timeout);
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 8'h08;
    step();
    req = 8'h48;
    step();
    n_tests++;
    if (b16.gnt !== 8'h08) begin
      n_fail++;
      $display("FAIL drop_hold: got %h want 08", b16.gnt);
    end
    req = 8'h40;
    step();
    n_tests++;
    if ({b16.gnt, b16.gnt_valid, b16.timeout} !== 10'h0) begin
      n_fail++;
      $display("FAIL drop_rel: got %h/%b/%b want 00/0/0",
        b16.gnt, b16.gnt_valid, b16.timeout);
    end
    step();
    n_tests++;
    if ({b16.gnt, b16.gnt_idx} !== {8'h40, 3'd6}) begin
      n_fail++;
      $display("FAIL drop_next: got %h/%0d want 40/6",
        b16.gnt, b16.gnt_idx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40;
    step();
    n_tests++;
    if (b16.gnt !== 8'h40) begin
      n_fail++;
      $display("FAIL rmid_grant: got %h want 40", b16.gnt);
    end
    req  = 8'hFF;
    done = 1'b1;
    rst  = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({o_gnt[i], o_idx[i], o_vld[i], o_to[i]}
          !== 13'h0) begin
        n_fail++;
        $display("FAIL rmid_vals inst%0d: got %h want 0",
          i, {o_gnt[i], o_idx[i], o_vld[i], o_to[i]});
      end
    end
    rst  = 1'b0;
    done = 1'b0;
    step();
    n_tests++;
    if (b16.gnt !== 8'h01) begin
      n_fail++;
      $display("FAIL rmid_next: got %h want 01", b16.gnt);
    end
  endtask

  task automatic test_fairness();
    int g;
    int last_c;
    bit prev;
    do_reset();
    req    = 8'hFF;
    done   = 1'b0;
    g      = 0;
    last_c = 0;
    prev   = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (b4.gnt_valid && !prev) begin
        n_tests++;
        if (b4.gnt_idx !== 3'(g % 8)) begin
          n_fail++;
          $display("FAIL fair_idx g%0d: got %0d want %0d",
            g, b4.gnt_idx, g % 8);
        end
        if (g > 0) begin
          n_tests++;
          if (c - last_c !== 5) begin
            n_fail++;
            $display("FAIL fair_gap g%0d: got %0d want 5",
              g, c - last_c);
          end
        end
        last_c = c;
        g++;
      end
      prev = b4.gnt_valid;
    end
    n_tests++;
    if (g !== 16) begin
      n_fail++;
      $display("FAIL fair_count: got %0d want 16", g);
    end
  endtask

  task automatic test_random();
    logic [7:0] eg;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        eg = m_gnt(i);
        n_tests++;
        if ({o_gnt[i], o_idx[i], o_vld[i], o_to[i]}
            !== {eg, m_idx[i], m_act[i], m_to[i]}) begin
          n_fail++;
          $display("FAIL rand c%0d inst%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
            c, i, o_gnt[i], o_idx[i], o_vld[i], o_to[i],
            eg, m_idx[i], m_act[i], m_to[i]);
        end
      end
    end
    rst  = 1'b0;
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single();
    test_rotation(8'h81, 4);
    test_rotation(8'hFF, 9);
    test_timeout();
    test_drop();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter that shares one 3-to-8 decoded select resource among eight requesters. It picks one requester at a time with a rotating-priority pointer. It issues a one-hot grant (the 3-bit winner index expanded 3-to-8) plus the binary index, and holds the grant until release, requester drop or timeout. It sits between the requesting agents and the decoded-select datapath and is the only driver of that datapath's select inputs.

## Interface
Parameters:
- TIMEOUT, default 16: maximum consecutive cycles a grant may be held; range 0..255; 0 disables timeout.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  reset; synchronous, active-high.
- req  input  8  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  current owner releases the resource; sampled only while gnt_valid=1.
- gnt  output  8  one-hot grant, registered; all zero when no grant.
- gnt_idx  output  3  binary index of current/last owner, registered.
- gnt_valid  output  1  registered; 1 while a grant is active.
- timeout  output  1  registered one-cycle pulse; grant revoked by timeout.

## Operation
- Two states: IDLE, GRANT. Internal pointer last[2:0]; hold counter cnt[7:0].
- Reset (rst=1 at a clock edge) has priority over all other inputs and forces state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, last=3'd7, cnt=0. Because last=7 after reset, requester 0 has first priority.
- IDLE: if req==0, stay in IDLE with outputs unchanged (gnt_idx keeps its last value). Otherwise select the first set bit of req searching upward from (last+1) mod 8, with wrap 7→0. The winner is w.
  - On the next edge: gnt=1<<w (exact 3-to-8 decode of w), gnt_idx=w, gnt_valid=1, last=w, cnt=0, state=GRANT.
- GRANT: each cycle, evaluate in priority order:
  1. done=1: release, timeout stays 0.
  2. req[gnt_idx]=0 (requester dropped): release, timeout stays 0.
  3. TIMEOUT≠0 and cnt==TIMEOUT-1: release, timeout=1 for exactly the following cycle.
  4. Otherwise: cnt=cnt+1 (8-bit, no wrap is reachable because TIMEOUT≤255), stay in GRANT.
- Release: on the next edge gnt=0, gnt_valid=0, state=IDLE; gnt_idx keeps the released index.
- Changes to req bits other than the owner's have no effect during GRANT.
- Invariants:
  - gnt is always zero or exactly one-hot.
  - gnt==(1<<gnt_idx) whenever gnt_valid=1.
  - timeout=1 only in the cycle after a timeout release, when gnt_valid=0.
- With TIMEOUT=0 a grant lasts until done or the requester drops.

## Timing
- Arbitration latency: req sampled at edge N (state IDLE) → gnt/gnt_valid high after edge N, i.e. visible in cycle N+1.
- Release latency: done/drop/timeout condition at edge M → gnt low in cycle M+1.
- Mandatory one-cycle IDLE gap between consecutive grants. Back-to-back grants are therefore spaced at least 2 cycles apart (grant cycle plus gap cycle).
- Grant duration:
  - With done asserted in the first grant cycle: 1 cycle.
  - With no done and no drop: exactly TIMEOUT cycles.
- Simultaneous done and timeout condition: done wins, timeout stays 0.
- Simultaneous done and owner-drop: single release, no timeout.
- Reset during GRANT: next cycle all outputs at reset values and last=7, regardless of done/req.
- Fairness: with all 8 requesting continuously and TIMEOUT=4, grants rotate 0,1,…,7,0. Each requester is served once per 8×(4+1)=40 cycles.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=8'hFF → gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0. Release rst → grant to requester 0 (gnt=8'h01) one cycle after the first IDLE sample.
- Single requester: req=8'h20 and done pulsed 3 cycles after grant → gnt=8'h20, gnt_idx=5 for 4 cycles. Then gnt=0 with gnt_idx=5 retained. Re-grant to 5 after the 1-cycle gap if req persists.
- Rotation and wrap: TIMEOUT=0, req=8'h81, owner asserts done on its first grant cycle → grant sequence 0,7,0,7 with one-cycle gaps. Also with req=8'hFF: sequence 0..7 then wraps to 0.
- Timeout: TIMEOUT=16, req=8'h04 held, done=0 → gnt=8'h04 for exactly 16 cycles, then gnt=0 and timeout=1 for one cycle. Additionally, done coinciding with cnt==15 → timeout stays 0.
- Requester drop: owner 3 granted, req[3] cleared while req[6]=1 → gnt=0 next cycle, timeout=0, then gnt=8'h40 one cycle later.
- Reset mid-grant: owner 6 granted, rst pulsed with req=8'hFF, done=1 → reset values next cycle. The next grant goes to 0, not 7.
